fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Write-side arbiter and burst sequencer for the 16-bit x 64 async FIFO.
- Shares the single FIFO write port among NUM_REQ requesters in the wr_clk domain, using round-robin arbitration.
- Grants a whole burst only when the FIFO has enough free space for all of it, so a granted burst never has to stop partway.
- Connects to the FIFO's wr_en/wr_data/wr_full/wr_usedw ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, data width; equals the FIFO data width.
- DEPTH, 64, FIFO depth; power of 2.
- USEDW_W, $clog2(DEPTH), width of the FIFO wr_usedw port.
- MAX_BURST, 16, maximum beats per grant; must be <= DEPTH.
- LEN_W, $clog2(MAX_BURST+1), width of each requester's length field.

Ports:
- wr_clk  in  1  write-domain clock.
- wrst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester burst request, level.
- req_len  in  NUM_REQ*LEN_W  packed burst length; slice i belongs to requester i.
- req_data  in  NUM_REQ*DATA_W  packed write data; slice i belongs to requester i.
- gnt  out  NUM_REQ  one-hot grant, held for the whole burst.
- beat_ack  out  NUM_REQ  one-hot per-beat accept strobe.
- busy  out  1  high while a burst is in progress.
- cur_id  out  $clog2(NUM_REQ)  index of the granted requester.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_W  FIFO write data.
- fifo_wr_full  in  1  FIFO wr_full.
- fifo_wr_usedw  in  USEDW_W  FIFO wr_usedw.

Behaviour:
- Reset: wrst_n is asynchronous and active-low; clock is wr_clk.
- Reset values: state=IDLE, gnt=0, beat_ack=0, busy=0, cur_id=0, fifo_wr_en=0, beat counter=0, rr_last=NUM_REQ-1 (requester 0 has first priority).
- Free space: free = fifo_wr_full ? 0 : DEPTH - fifo_wr_usedw, computed USEDW_W+1 bits wide.
  - usedw=0 with full=0 gives free=DEPTH.
  - The value is conservative because of read-pointer sync lag; no extra margin is added.
- Effective length: eff_len_i = min(req_len_i, MAX_BURST).
- Eligibility: requester i is eligible when req[i]=1, req_len_i != 0, and eff_len_i <= free.
  - req_len=0 is never eligible.
- FSM has two states, IDLE and BURST.
- IDLE:
  - Search eligible requesters in order rr_last+1 .. rr_last+NUM_REQ, modulo NUM_REQ.
  - On a hit at edge k: state->BURST, gnt[i]=1, cur_id=i, busy=1, beat counter=eff_len_i, rr_last=i.
  - Ineligible requesters are skipped, not waited for; a large request can be overtaken while space is short.
  - If nothing is eligible, stay in IDLE.
- BURST:
  - Combinational: fifo_wr_en = !fifo_wr_full.
  - Combinational: beat_ack[cur_id] = fifo_wr_en.
  - fifo_wr_data = req_data slice cur_id, driven in every state.
  - Each accepted beat decrements the counter.
  - If fifo_wr_full=1, the beat is held with no ack and no decrement. This is a safety guard only; it must not occur after the space check.
  - Final beat (counter=1 and accepted): at the next edge state->IDLE, and gnt, busy and the counter clear.
  - There is always exactly one IDLE cycle between bursts.
- Latency: a request sampled at edge k gets gnt and its first write in cycle k+1. A burst of N beats with no stall occupies cycles k+1..k+N.
- Requester contract:
  - Data for the current beat is valid while gnt is high.
  - The requester advances to its next word on the edge where beat_ack is high.
- Deasserting req mid-burst does not abort the burst; all eff_len beats are written.
- req_len is sampled only at grant; changes during BURST are ignored.
- Reset asserted mid-burst: all outputs go to reset values immediately. Beats already written stay in the FIFO; the rest of the burst is dropped.
- Assertions:
  - gnt is one-hot or zero.
  - beat_ack is a subset of gnt.
  - fifo_wr_en is never high when fifo_wr_full=1.

Test Plan:
- Single requester: req[0] len 4, FIFO empty, req at edge 0 -> gnt=0001 in cycles 1-4, fifo_wr_en high 4 cycles, data D0..D3 written in order, busy low at cycle 5.
- Round-robin: req[0],req[1],req[2] all high, len 2 each, empty FIFO -> grant order 0,1,2, then 0 again if still requesting; one idle cycle between bursts; 6 words total in order A0 A1 B0 B1 C0 C1.
- Space skip: usedw=56 (free 8), req[0] len 16, req[1] len 4 -> requester 1 granted, 0 skipped. After reads bring usedw to 40 (free 24) -> requester 0 granted with 16 beats.
- Clamp/zero: req_len=31 -> exactly 16 beats written. req_len=0 with req high -> no grant ever, gnt stays 0.
- Full guard: force fifo_wr_full=1 for 3 cycles mid-burst -> fifo_wr_en and beat_ack low for those cycles, counter holds, burst resumes and completes its full length.
- Reset mid-burst: assert wrst_n low after beat 2 of 8 -> gnt, busy, fifo_wr_en all 0 asynchronously. After release, rr_last=NUM_REQ-1 and requester 0 has first priority.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Write-side arbiter and burst sequencer for the 16-bit x 64 async FIFO.
//   NUM_REQ requesters in the wr_clk domain share the single FIFO write port.
//   Arbitration is round-robin. A burst is granted only when the FIFO
//   already has room for every beat, so a granted burst runs without gaps.
//
// Ports
//   wr_clk, wrst_n   write-domain clock, asynchronous active-low reset
//   req              per-requester burst request (level)
//   req_len          packed burst lengths, slice i = requester i
//   req_data         packed write data, slice i = requester i
//   gnt              one-hot grant, held for the whole burst
//   beat_ack         one-hot per-beat accept strobe (requester advances on it)
//   busy             high while a burst is in progress
//   cur_id           index of the granted requester
//   fifo_wr_en       FIFO write enable
//   fifo_wr_data     FIFO write data (muxed from cur_id in every state)
//   fifo_wr_full     FIFO wr_full
//   fifo_wr_usedw    FIFO wr_usedw
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 64,
  parameter int USEDW_W   = $clog2(DEPTH),
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                        wr_clk,
  input  logic                        wrst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          beat_ack,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  cur_id,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_wr_data,
  input  logic                        fifo_wr_full,
  input  logic [USEDW_W-1:0]          fifo_wr_usedw
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int FREE_W = USEDW_W + 1;
  localparam int CMP_W  = (LEN_W > FREE_W) ? LEN_W : FREE_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic [LEN_W-1:0]   beat_cnt;
  logic [ID_W-1:0]    rr_last;
  logic [FREE_W-1:0]  free;
  logic [LEN_W-1:0]   eff_len [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic               hit;
  logic [ID_W-1:0]    hit_id;
  int                 idx;

  // One extra bit so an empty FIFO reports the full DEPTH. The usedw value
  // lags reads, so this is already a safe under-estimate of real space.
  assign free = fifo_wr_full ? '0 : (FREE_W'(DEPTH) - FREE_W'(fifo_wr_usedw));

  always_comb begin
    eff_len  = '{default: '0};
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eff_len[i] = (req_len[i*LEN_W +: LEN_W] > MAX_LEN) ? MAX_LEN
                                                          : req_len[i*LEN_W +: LEN_W];
      eligible[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0)
                    && (CMP_W'(eff_len[i]) <= CMP_W'(free));
    end
  end

  // Round-robin search starting just after the last winner. Ineligible
  // requesters are skipped, so a short burst can overtake a long one.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (!hit && eligible[idx]) begin
        hit    = 1'b1;
        hit_id = ID_W'(idx);
      end
    end
  end

  // The full check is only a safety net: the grant-time space check means
  // a running burst should never actually see full.
  assign fifo_wr_en   = (state == BURST) && !fifo_wr_full;
  assign beat_ack     = NUM_REQ'(fifo_wr_en) << cur_id;
  assign fifo_wr_data = req_data[int'(cur_id)*DATA_W +: DATA_W];

  always_ff @(posedge wr_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
      cur_id   <= '0;
      beat_cnt <= '0;
      rr_last  <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state    <= BURST;
            gnt      <= NUM_REQ'(1) << hit_id;
            cur_id   <= hit_id;
            busy     <= 1'b1;
            beat_cnt <= eff_len[hit_id];
            rr_last  <= hit_id;
          end
        end
        BURST: begin
          if (fifo_wr_en) begin
            // Returning to IDLE forces one idle cycle between bursts.
            if (beat_cnt == LEN_W'(1)) begin
              state    <= IDLE;
              gnt      <= '0;
              busy     <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge wr_clk) disable iff (!wrst_n)
    $onehot0(gnt));
  a_ack_in_gnt: assert property (@(posedge wr_clk) disable iff (!wrst_n)
    ((beat_ack & ~gnt) == '0));
  a_no_wr_full: assert property (@(posedge wr_clk) disable iff (!wrst_n)
    !(fifo_wr_en && fifo_wr_full));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter. A behavioural model (busy flag,
//   remaining-beat count, round-robin pointer) predicts the outputs each
//   cycle; directed tests pin the model with literal write sequences.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 16;
  localparam int DEPTH     = 64;
  localparam int USEDW_W   = 6;
  localparam int MAX_BURST = 16;
  localparam int LEN_W     = 5;

  logic                      wr_clk = 1'b0;
  logic                      wrst_n = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*LEN_W-1:0]  req_len = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        beat_ack;
  logic                      busy;
  logic [1:0]                cur_id;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      fifo_wr_full = 1'b0;
  logic [USEDW_W-1:0]        fifo_wr_usedw = '0;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .USEDW_W(USEDW_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)
  ) dut (
    .wr_clk(wr_clk), .wrst_n(wrst_n), .req(req), .req_len(req_len),
    .req_data(req_data), .gnt(gnt), .beat_ack(beat_ack), .busy(busy),
    .cur_id(cur_id), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full), .fifo_wr_usedw(fifo_wr_usedw)
  );

  // Free-running write clock, 10 time units per cycle.
  always #5 wr_clk = ~wr_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word j of requester i: A000+j, B000+j, C000+j, D000+j.
  function automatic logic [15:0] word(input int i, input int j);
    return 16'(32'hA000 + i * 32'h1000 + j);
  endfunction

  function automatic logic [NUM_REQ*LEN_W-1:0] packLens(input int l0, input int l1, input int l2, input int l3);
    return {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
  endfunction

  // Requesters: each presents its current word and steps to the next one on
  // the edge that ends a cycle in which its beat_ack was high.
  int                 drv_ptr [NUM_REQ] = '{default: 0};
  logic [NUM_REQ-1:0] ack_neg = '0;
  logic               ptr_clr = 1'b1;

  always @(negedge wr_clk) ack_neg <= beat_ack;

  always @(posedge wr_clk) begin
    if (ptr_clr) begin
      for (int i = 0; i < NUM_REQ; i++) drv_ptr[i] <= 0;
    end else if (wrst_n) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (ack_neg[i]) drv_ptr[i] <= drv_ptr[i] + 1;
    end
  end

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = word(i, drv_ptr[i]);
  end

  // Behavioural model: free space, clamped length and a round-robin search.
  function automatic int lenOf(input logic [NUM_REQ*LEN_W-1:0] lens, input int i);
    return int'(lens[i*LEN_W +: LEN_W]);
  endfunction

  function automatic int effLen(input int len);
    return (len > MAX_BURST) ? MAX_BURST : len;
  endfunction

  function automatic int pickNext(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*LEN_W-1:0] lens,
                                  input int last, input int space);
    pickNext = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last + k) % NUM_REQ;
      if (pickNext < 0 && r[i] && lenOf(lens, i) != 0 && effLen(lenOf(lens, i)) <= space)
        pickNext = i;
    end
  endfunction

  logic m_busy = 1'b0;
  int   m_id = 0;
  int   m_left = 0;
  int   m_last = NUM_REQ - 1;
  int   m_ptr [NUM_REQ] = '{default: 0};
  int   m_free;
  int   m_pick;

  assign m_free = fifo_wr_full ? 0 : DEPTH - int'(fifo_wr_usedw);
  assign m_pick = pickNext(req, req_len, m_last, m_free);

  // Model burst state: a busy flag plus the count of beats still owed.
  always @(posedge wr_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_last <= NUM_REQ - 1;
    end else if (m_busy) begin
      if (!fifo_wr_full) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_busy <= 1'b0;
      end
    end else if (m_pick >= 0) begin
      m_busy <= 1'b1;
      m_id   <= m_pick;
      m_left <= effLen(lenOf(req_len, m_pick));
      m_last <= m_pick;
    end
  end

  // Model view of each requester's position in its data stream.
  always @(posedge wr_clk) begin
    if (ptr_clr) begin
      for (int i = 0; i < NUM_REQ; i++) m_ptr[i] <= 0;
    end else if (wrst_n && m_busy && !fifo_wr_full) begin
      m_ptr[m_id] <= m_ptr[m_id] + 1;
    end
  end

  logic [NUM_REQ-1:0] e_gnt;
  logic [NUM_REQ-1:0] e_ack;
  logic               e_wen;
  logic [15:0]        e_data;

  assign e_gnt  = m_busy ? (NUM_REQ'(1) << m_id) : '0;
  assign e_wen  = m_busy && !fifo_wr_full;
  assign e_ack  = e_wen ? e_gnt : '0;
  assign e_data = word(m_id, m_ptr[m_id]);

  // Per-cycle compare against the model, sampled mid-cycle.
  logic chk_en = 1'b0;

  always @(negedge wr_clk) begin
    if (chk_en) begin
      checkOutput("gnt", 32'(gnt), 32'(e_gnt));
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wen));
      checkOutput("beat_ack", 32'(beat_ack), 32'(e_ack));
      if (m_busy) begin
        checkOutput("cur_id", 32'(cur_id), 32'(m_id));
        checkOutput("fifo_wr_data", 32'(fifo_wr_data), 32'(e_data));
      end
    end
  end

  // Log of words actually written into the FIFO, with the cycle of each.
  logic [15:0] log_data [$];
  int          log_cyc [$];
  int          cyc = 0;
  logic [15:0] exp_q [$];

  always @(posedge wr_clk) begin
    cyc <= cyc + 1;
    if (wrst_n && fifo_wr_en) begin
      log_data.push_back(fifo_wr_data);
      log_cyc.push_back(cyc);
    end
  end

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*LEN_W-1:0] lens,
                               input int usedw, input logic full);
    req           = r;
    req_len       = lens;
    fifo_wr_usedw = USEDW_W'(usedw);
    fifo_wr_full  = full;
  endtask

  task automatic checkWords(input string name, input int base);
    for (int j = 0; j < exp_q.size(); j++)
      checkOutput($sformatf("%s%0d", name, j), 32'(log_data[base + j]), 32'(exp_q[j]));
  endtask

  task automatic resetDut();
    @(posedge wr_clk); #1;
    wrst_n = 1'b0;
    applyStimulus('0, '0, 0, 1'b0);
    ptr_clr = 1'b1;
    @(posedge wr_clk); #1;
    ptr_clr = 1'b0;
    log_data.delete();
    log_cyc.delete();
    @(posedge wr_clk); #1;
    wrst_n = 1'b1;
  endtask

  task automatic waitGrant(input string name);
    logic found;
    int   n;
    found = 1'b0;
    n = 0;
    while (!found && n < 64) begin
      @(negedge wr_clk);
      n++;
      if (gnt != '0) found = 1'b1;
    end
    checkOutput(name, 32'(found), 32'd1);
  endtask

  task automatic waitIdle(input string name);
    logic idle;
    int   n;
    idle = 1'b0;
    n = 0;
    while (!idle && n < 64) begin
      @(negedge wr_clk);
      n++;
      if (!busy) idle = 1'b1;
    end
    checkOutput(name, 32'(idle), 32'd1);
  endtask

  task automatic waitLog(input string name, input int count);
    int n;
    n = 0;
    while (log_data.size() < count && n < 200) begin
      @(posedge wr_clk); #1;
      n++;
    end
    checkOutput(name, 32'(log_data.size() >= count), 32'd1);
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int gc;

    #2;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cur_id", 32'(cur_id), 32'd0);
    checkOutput("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    checkOutput("rst_beat_ack", 32'(beat_ack), 32'd0);
    @(posedge wr_clk); #1;
    ptr_clr = 1'b0;
    @(posedge wr_clk); #1;
    wrst_n = 1'b1;
    chk_en = 1'b1;

    $display("[TB] single requester, 4 beats");
    applyStimulus(4'b0001, packLens(4, 0, 0, 0), 0, 1'b0);
    waitGrant("t1_wait_gnt");
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    @(posedge wr_clk); #1;
    req = '0;
    waitIdle("t1_wait_idle");
    checkOutput("t1_count", 32'(log_data.size()), 32'd4);
    exp_q = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    checkWords("t1_word", 0);
    checkOutput("t1_contiguous", 32'(log_cyc[3] - log_cyc[0]), 32'd3);

    $display("[TB] round-robin over three requesters");
    resetDut();
    applyStimulus(4'b0111, packLens(2, 2, 2, 0), 0, 1'b0);
    waitLog("t2_wait_log", 8);
    req = '0;
    waitIdle("t2_wait_idle");
    repeat (3) @(posedge wr_clk);
    #1;
    checkOutput("t2_count", 32'(log_data.size()), 32'd8);
    exp_q = '{16'hA000, 16'hA001, 16'hB000, 16'hB001, 16'hC000, 16'hC001, 16'hA002, 16'hA003};
    checkWords("t2_word", 0);
    checkOutput("t2_gap_ab", 32'(log_cyc[2] - log_cyc[1]), 32'd2);
    checkOutput("t2_gap_bc", 32'(log_cyc[4] - log_cyc[3]), 32'd2);

    $display("[TB] space skip");
    resetDut();
    applyStimulus(4'b0011, packLens(16, 4, 0, 0), 56, 1'b0);
    waitGrant("t3_wait_gnt1");
    checkOutput("t3_gnt1", 32'(gnt), 32'h2);
    @(posedge wr_clk); #1;
    req = 4'b0001;
    waitIdle("t3_wait_idle1");
    repeat (4) @(posedge wr_clk);
    #1;
    checkOutput("t3_count1", 32'(log_data.size()), 32'd4);
    exp_q = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
    checkWords("t3_b_word", 0);
    fifo_wr_usedw = 6'd40;
    waitGrant("t3_wait_gnt0");
    checkOutput("t3_gnt0", 32'(gnt), 32'h1);
    @(posedge wr_clk); #1;
    req = '0;
    waitIdle("t3_wait_idle0");
    checkOutput("t3_count0", 32'(log_data.size()), 32'd20);
    exp_q.delete();
    for (int j = 0; j < 16; j++) exp_q.push_back(16'hA000 + 16'(j));
    checkWords("t3_a_word", 4);

    $display("[TB] length clamp and zero length");
    resetDut();
    applyStimulus(4'b0001, packLens(31, 0, 0, 0), 0, 1'b0);
    waitGrant("t4_wait_gnt");
    @(posedge wr_clk); #1;
    req = '0;
    waitIdle("t4_wait_idle");
    checkOutput("t4_count", 32'(log_data.size()), 32'd16);
    checkOutput("t4_last", 32'(log_data[15]), 32'hA00F);
    applyStimulus(4'b0010, packLens(0, 0, 0, 0), 0, 1'b0);
    gc = 0;
    repeat (10) begin
      @(negedge wr_clk);
      if (gnt != '0) gc++;
    end
    checkOutput("t4_zero_no_gnt", 32'(gc), 32'd0);
    req = '0;

    $display("[TB] full guard mid-burst");
    resetDut();
    applyStimulus(4'b0001, packLens(8, 0, 0, 0), 0, 1'b0);
    waitGrant("t5_wait_gnt");
    @(posedge wr_clk); #1;
    req = '0;
    waitLog("t5_wait_log", 2);
    fifo_wr_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge wr_clk);
      checkOutput($sformatf("t5_stall_wr_en%0d", s), 32'(fifo_wr_en), 32'd0);
      checkOutput($sformatf("t5_stall_ack%0d", s), 32'(beat_ack), 32'd0);
      @(posedge wr_clk); #1;
    end
    fifo_wr_full = 1'b0;
    waitIdle("t5_wait_idle");
    checkOutput("t5_count", 32'(log_data.size()), 32'd8);
    exp_q.delete();
    for (int j = 0; j < 8; j++) exp_q.push_back(16'hA000 + 16'(j));
    checkWords("t5_word", 0);
    checkOutput("t5_stall_gap", 32'(log_cyc[2] - log_cyc[1]), 32'd4);

    $display("[TB] reset mid-burst");
    resetDut();
    applyStimulus(4'b0001, packLens(8, 0, 0, 0), 0, 1'b0);
    waitGrant("t6_wait_gnt");
    @(posedge wr_clk); #1;
    req = '0;
    waitLog("t6_wait_log", 2);
    #1;
    wrst_n = 1'b0;
    #1;
    checkOutput("t6_rst_gnt", 32'(gnt), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    checkOutput("t6_rst_ack", 32'(beat_ack), 32'd0);
    checkOutput("t6_rst_cur_id", 32'(cur_id), 32'd0);
    repeat (2) @(posedge wr_clk);
    #1;
    checkOutput("t6_kept", 32'(log_data.size()), 32'd2);
    applyStimulus(4'b0011, packLens(2, 2, 0, 0), 0, 1'b0);
    wrst_n = 1'b1;
    waitGrant("t6_wait_gnt2");
    checkOutput("t6_first_prio", 32'(gnt), 32'h1);
    @(posedge wr_clk); #1;
    req = '0;
    waitIdle("t6_wait_idle");
    checkOutput("t6_count", 32'(log_data.size()), 32'd4);
    exp_q = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    checkWords("t6_word", 0);

    repeat (2) @(posedge wr_clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
